// File: rtl/mips_decode_stage.sv
`timescale 1ns/1ps
// mips_decode_stage: MIPS-I decode/issue stage with branch resolution and a load scoreboard.
// Build macro WB_BYPASS_EN forwards writeback data into operand read and releases the stall early.
module mips_decode_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int OP_W   = 4,
    localparam int RA_W  = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_ins_i,
    input  logic [DATA_W-1:0] in_pc_i,
    output logic [RA_W-1:0]   rf_raddr1_o,
    output logic [RA_W-1:0]   rf_raddr2_o,
    input  logic [DATA_W-1:0] rf_rdata1_i,
    input  logic [DATA_W-1:0] rf_rdata2_i,
    input  logic              wb_en_i,
    input  logic [RA_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OP_W-1:0]   out_op_o,
    output logic [DATA_W-1:0] out_a_o,
    output logic [DATA_W-1:0] out_b_o,
    output logic [DATA_W-1:0] out_store_o,
    output logic [RA_W-1:0]   out_waddr_o,
    output logic              out_wreg_o,
    output logic              out_mem_rd_o,
    output logic              out_mem_wr_o,
    output logic              out_illegal_o,
    output logic              redirect_o,
    output logic [DATA_W-1:0] redirect_pc_o
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LUI  = OP_W'(11);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [4:0]  f_shamt;
    logic [15:0] imm;
    logic [25:0] idx;

    assign opcode  = in_ins_i[31:26];
    assign f_rs    = in_ins_i[25:21];
    assign f_rt    = in_ins_i[20:16];
    assign f_rd    = in_ins_i[15:11];
    assign f_shamt = in_ins_i[10:6];
    assign funct   = in_ins_i[5:0];
    assign imm     = in_ins_i[15:0];
    assign idx     = in_ins_i[25:0];

    assign rf_raddr1_o = RA_W'(f_rs);
    assign rf_raddr2_o = RA_W'(f_rt);

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [NREG-1:0]   busy_src;

`ifdef WB_BYPASS_EN
    logic            rs_byp;
    logic            rt_byp;
    logic [NREG-1:0] wb_hit;

    assign rs_byp = wb_en_i && (wb_addr_i == rf_raddr1_o) && (rf_raddr1_o != '0);
    assign rt_byp = wb_en_i && (wb_addr_i == rf_raddr2_o) && (rf_raddr2_o != '0);
    assign rs_val = rs_byp ? wb_data_i : rf_rdata1_i;
    assign rt_val = rt_byp ? wb_data_i : rf_rdata2_i;

    // A register being written back this cycle is no longer a hazard.
    always_comb begin
        wb_hit = '0;
        if (wb_en_i) wb_hit[wb_addr_i] = 1'b1;
    end
    assign busy_src = busy_q & ~wb_hit;
`else
    logic unused_wb_data;

    assign rs_val         = rf_rdata1_i;
    assign rt_val         = rf_rdata2_i;
    assign busy_src       = busy_q;
    assign unused_wb_data = ^wb_data_i;
`endif

    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] zext_imm;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] pc_plus8;
    logic [DATA_W-1:0] br_target;
    logic [DATA_W-1:0] j_target;
    logic              rs_eq_rt;
    logic              rs_lez;

    assign sext_imm  = {{(DATA_W-16){imm[15]}}, imm};
    assign zext_imm  = {{(DATA_W-16){1'b0}}, imm};
    assign pc_plus4  = in_pc_i + DATA_W'(4);
    assign pc_plus8  = in_pc_i + DATA_W'(8);
    assign br_target = pc_plus4 + (sext_imm << 2);
    assign j_target  = DATA_W'({pc_plus4[DATA_W-1 -: 4], idx, 2'b00});
    assign rs_eq_rt  = (rs_val == rt_val);
    assign rs_lez    = rs_val[DATA_W-1] | (rs_val == '0);

    logic [OP_W-1:0]   dec_op;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic [RA_W-1:0]   dec_waddr;
    logic              dec_wreg;
    logic              dec_mem_rd;
    logic              dec_mem_wr;
    logic              dec_illegal;
    logic              dec_taken;
    logic [DATA_W-1:0] dec_target;
    logic              rs_used;
    logic              rt_used;

    always_comb begin
        dec_op      = OP_ADD;
        dec_a       = '0;
        dec_b       = '0;
        dec_waddr   = '0;
        dec_wreg    = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_illegal = 1'b0;
        dec_taken   = 1'b0;
        dec_target  = '0;
        rs_used     = 1'b0;
        rt_used     = 1'b0;
        case (opcode)
            6'h00: begin
                dec_waddr = RA_W'(f_rd);
                dec_wreg  = 1'b1;
                dec_a     = rs_val;
                dec_b     = rt_val;
                rs_used   = 1'b1;
                rt_used   = 1'b1;
                case (funct)
                    6'h00: begin dec_op = OP_SLL; dec_a = DATA_W'(f_shamt); rs_used = 1'b0; end
                    6'h02: begin dec_op = OP_SRL; dec_a = DATA_W'(f_shamt); rs_used = 1'b0; end
                    6'h03: begin dec_op = OP_SRA; dec_a = DATA_W'(f_shamt); rs_used = 1'b0; end
                    6'h04: begin dec_op = OP_SLL; dec_a = DATA_W'(rs_val[4:0]); end
                    6'h06: begin dec_op = OP_SRL; dec_a = DATA_W'(rs_val[4:0]); end
                    6'h07: begin dec_op = OP_SRA; dec_a = DATA_W'(rs_val[4:0]); end
                    6'h08: begin
                        dec_wreg   = 1'b0;
                        dec_b      = '0;
                        rt_used    = 1'b0;
                        dec_taken  = 1'b1;
                        dec_target = rs_val;
                    end
                    6'h20, 6'h21: dec_op = OP_ADD;
                    6'h22, 6'h23: dec_op = OP_SUB;
                    6'h24: dec_op = OP_AND;
                    6'h25: dec_op = OP_OR;
                    6'h26: dec_op = OP_XOR;
                    6'h27: dec_op = OP_NOR;
                    6'h2A: dec_op = OP_SLT;
                    6'h2B: dec_op = OP_SLTU;
                    default: begin
                        dec_illegal = 1'b1;
                        dec_wreg    = 1'b0;
                        rs_used     = 1'b0;
                        rt_used     = 1'b0;
                    end
                endcase
            end
            6'h02: begin
                dec_taken  = 1'b1;
                dec_target = j_target;
            end
            6'h03: begin
                dec_taken  = 1'b1;
                dec_target = j_target;
                dec_a      = pc_plus8;
                dec_waddr  = RA_W'(31);
                dec_wreg   = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dec_op     = OP_SUB;
                dec_a      = rs_val;
                dec_b      = rt_val;
                rs_used    = 1'b1;
                rt_used    = !opcode[1];
                dec_target = br_target;
                case (opcode[1:0])
                    2'b00:   dec_taken = rs_eq_rt;
                    2'b01:   dec_taken = !rs_eq_rt;
                    2'b10:   dec_taken = rs_lez;
                    default: dec_taken = !rs_lez;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                dec_a     = rs_val;
                dec_waddr = RA_W'(f_rt);
                dec_wreg  = 1'b1;
                rs_used   = 1'b1;
                case (opcode[2:0])
                    3'h0, 3'h1: begin dec_op = OP_ADD;  dec_b = sext_imm; end
                    3'h2:       begin dec_op = OP_SLT;  dec_b = sext_imm; end
                    3'h3:       begin dec_op = OP_SLTU; dec_b = sext_imm; end
                    3'h4:       begin dec_op = OP_AND;  dec_b = zext_imm; end
                    3'h5:       begin dec_op = OP_OR;   dec_b = zext_imm; end
                    default:    begin dec_op = OP_XOR;  dec_b = zext_imm; end
                endcase
            end
            6'h0F: begin
                dec_op    = OP_LUI;
                dec_b     = zext_imm;
                dec_waddr = RA_W'(f_rt);
                dec_wreg  = 1'b1;
            end
            6'h23: begin
                dec_a      = rs_val;
                dec_b      = sext_imm;
                dec_waddr  = RA_W'(f_rt);
                dec_wreg   = 1'b1;
                dec_mem_rd = 1'b1;
                rs_used    = 1'b1;
            end
            6'h2B: begin
                dec_a      = rs_val;
                dec_b      = sext_imm;
                dec_mem_wr = 1'b1;
                rs_used    = 1'b1;
                rt_used    = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_waddr == '0) dec_wreg = 1'b0;
    end

    logic stall;
    logic accept;
    logic out_valid_q;
    logic out_valid_d;
    logic redirect_q;
    logic redirect_d;

    assign stall      = (rs_used & busy_src[rf_raddr1_o]) | (rt_used & busy_src[rf_raddr2_o]);
    assign in_ready_o = !stall && (!out_valid_q || out_ready_i) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // Scoreboard: set beats clear for the same register; flush beats both.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_i) busy_d[wb_addr_i] = 1'b0;
        if (accept && dec_wreg && dec_mem_rd) busy_d[dec_waddr] = 1'b1;
        if (flush_i) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush_i)          out_valid_d = 1'b0;
        else if (accept)      out_valid_d = 1'b1;
        else if (out_ready_i) out_valid_d = 1'b0;
        redirect_d = accept && dec_taken;
    end

    logic [OP_W-1:0]   out_op_q;
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;
    logic [DATA_W-1:0] out_store_q;
    logic [RA_W-1:0]   out_waddr_q;
    logic              out_wreg_q;
    logic              out_mem_rd_q;
    logic              out_mem_wr_q;
    logic              out_illegal_q;
    logic [DATA_W-1:0] redirect_pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_store_q   <= '0;
            out_waddr_q   <= '0;
            out_wreg_q    <= 1'b0;
            out_mem_rd_q  <= 1'b0;
            out_mem_wr_q  <= 1'b0;
            out_illegal_q <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            busy_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            redirect_q  <= redirect_d;
            busy_q      <= busy_d;
            if (redirect_d) redirect_pc_q <= dec_target;
            if (accept) begin
                out_op_q      <= dec_op;
                out_a_q       <= dec_a;
                out_b_q       <= dec_b;
                out_store_q   <= rt_val;
                out_waddr_q   <= dec_waddr;
                out_wreg_q    <= dec_wreg;
                out_mem_rd_q  <= dec_mem_rd;
                out_mem_wr_q  <= dec_mem_wr;
                out_illegal_q <= dec_illegal;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_op_o      = out_op_q;
    assign out_a_o       = out_a_q;
    assign out_b_o       = out_b_q;
    assign out_store_o   = out_store_q;
    assign out_waddr_o   = out_waddr_q;
    assign out_wreg_o    = out_wreg_q;
    assign out_mem_rd_o  = out_mem_rd_q;
    assign out_mem_wr_o  = out_mem_wr_q;
    assign out_illegal_o = out_illegal_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_mips_decode_stage.sv
`timescale 1ns/1ps
// Bench for mips_decode_stage: directed scenarios plus a random instruction stream
// checked against an instruction-level decode model.
module tb_mips_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
    logic [31:0] in_ins, in_pc, rf_rdata1, rf_rdata2, wb_data;
    logic [4:0]  rf_raddr1, rf_raddr2, wb_addr, out_waddr;
    logic [3:0]  out_op;
    logic [31:0] out_a, out_b, out_store, redirect_pc;
    logic        out_wreg, out_mem_rd, out_mem_wr, out_illegal, redirect;

    logic [31:0] regs [32];
    int n_cmp = 0;
    int n_bad = 0;

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always #5 clk = ~clk;

    mips_decode_stage dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ins_i(in_ins), .in_pc_i(in_pc),
        .rf_raddr1_o(rf_raddr1), .rf_raddr2_o(rf_raddr2),
        .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_op_o(out_op),
        .out_a_o(out_a), .out_b_o(out_b), .out_store_o(out_store),
        .out_waddr_o(out_waddr), .out_wreg_o(out_wreg),
        .out_mem_rd_o(out_mem_rd), .out_mem_wr_o(out_mem_wr), .out_illegal_o(out_illegal),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
        logic [4:0]  waddr;
        logic        wreg, mrd, mwr, ill, redir;
        logic [31:0] rpc;
        logic        chk_op, chk_ab;
    } exp_t;

    // Instruction-level meaning of one MIPS-I word, given its operand values.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rsv, input logic [31:0] rtv);
        exp_t e;
        logic [31:0] sx, zx, pc4;
        e = '0;
        e.chk_op = 1'b1;
        e.chk_ab = 1'b1;
        e.store  = rtv;
        sx  = {{16{ins[15]}}, ins[15:0]};
        zx  = {16'h0, ins[15:0]};
        pc4 = pc + 32'd4;
        case (ins[31:26])
            6'h00: begin
                e.a = rsv; e.b = rtv; e.waddr = ins[15:11]; e.wreg = 1'b1;
                case (ins[5:0])
                    6'h00: begin e.op = 4'd8;  e.a = {27'h0, ins[10:6]}; end
                    6'h02: begin e.op = 4'd9;  e.a = {27'h0, ins[10:6]}; end
                    6'h03: begin e.op = 4'd10; e.a = {27'h0, ins[10:6]}; end
                    6'h04: begin e.op = 4'd8;  e.a = rsv % 32; end
                    6'h06: begin e.op = 4'd9;  e.a = rsv % 32; end
                    6'h07: begin e.op = 4'd10; e.a = rsv % 32; end
                    6'h08: begin e.wreg = 0; e.chk_op = 0; e.chk_ab = 0; e.redir = 1; e.rpc = rsv; end
                    6'h20, 6'h21: e.op = 4'd0;
                    6'h22, 6'h23: e.op = 4'd1;
                    6'h24: e.op = 4'd2;
                    6'h25: e.op = 4'd3;
                    6'h26: e.op = 4'd4;
                    6'h27: e.op = 4'd5;
                    6'h2A: e.op = 4'd6;
                    6'h2B: e.op = 4'd7;
                    default: begin e.ill = 1; e.wreg = 0; e.chk_op = 0; e.chk_ab = 0; end
                endcase
            end
            6'h02: begin e.chk_op = 0; e.chk_ab = 0; e.redir = 1; e.rpc = {pc4[31:28], ins[25:0], 2'b00}; end
            6'h03: begin
                e.op = 4'd0; e.a = pc + 32'd8; e.b = 32'd0; e.waddr = 5'd31; e.wreg = 1;
                e.redir = 1; e.rpc = {pc4[31:28], ins[25:0], 2'b00};
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                e.chk_op = 0; e.chk_ab = 0;
                e.rpc = pc4 + sx * 4;
                case (ins[31:26])
                    6'h04:   e.redir = (rsv == rtv);
                    6'h05:   e.redir = (rsv != rtv);
                    6'h06:   e.redir = ($signed(rsv) <= 0);
                    default: e.redir = ($signed(rsv) > 0);
                endcase
            end
            6'h08, 6'h09: begin e.op = 4'd0; e.a = rsv; e.b = sx; e.waddr = ins[20:16]; e.wreg = 1; end
            6'h0A: begin e.op = 4'd6; e.a = rsv; e.b = sx; e.waddr = ins[20:16]; e.wreg = 1; end
            6'h0B: begin e.op = 4'd7; e.a = rsv; e.b = sx; e.waddr = ins[20:16]; e.wreg = 1; end
            6'h0C: begin e.op = 4'd2; e.a = rsv; e.b = zx; e.waddr = ins[20:16]; e.wreg = 1; end
            6'h0D: begin e.op = 4'd3; e.a = rsv; e.b = zx; e.waddr = ins[20:16]; e.wreg = 1; end
            6'h0E: begin e.op = 4'd4; e.a = rsv; e.b = zx; e.waddr = ins[20:16]; e.wreg = 1; end
            6'h0F: begin e.op = 4'd11; e.chk_ab = 0; e.waddr = ins[20:16]; e.wreg = 1; end
            6'h23: begin e.op = 4'd0; e.a = rsv; e.b = sx; e.waddr = ins[20:16]; e.wreg = 1; e.mrd = 1; end
            6'h2B: begin e.op = 4'd0; e.a = rsv; e.b = sx; e.mwr = 1; end
            default: begin e.ill = 1; e.chk_op = 0; e.chk_ab = 0; end
        endcase
        if (e.waddr == 5'd0) e.wreg = 1'b0;
        return e;
    endfunction

    localparam logic [5:0] OPC_TAB [0:22] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04,
        6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
        6'h2B, 6'h01, 6'h20, 6'h3F};
    localparam logic [5:0] FN_TAB [0:19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h0C, 6'h18, 6'h09};

    // Send one instruction with out_ready high; returns on the negedge after acceptance.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1; in_ins = ins; in_pc = pc;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_ins = 0; in_pc = 0; out_ready = 1; flush = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL reset_redirect: got %b want 0", redirect); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_bad++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        n_cmp++; if ({out_op, out_a, out_b, out_wreg, out_mem_rd} !== '0) begin n_bad++; $display("FAIL reset_payload: nonzero after reset"); end
        @(negedge clk);
    endtask

    task automatic test_alu();
        regs[1] = 32'd5; regs[2] = 32'd7;
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'h0000_0040);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL addu_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_op !== 4'd0) begin n_bad++; $display("FAIL addu_op: got %0d want 0", out_op); end
        n_cmp++; if (out_a !== 32'd5 || out_b !== 32'd7) begin n_bad++; $display("FAIL addu_ab: got %h %h want 5 7", out_a, out_b); end
        n_cmp++; if (out_waddr !== 5'd3 || out_wreg !== 1'b1) begin n_bad++; $display("FAIL addu_dst: got %0d/%b want 3/1", out_waddr, out_wreg); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL addu_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_imm();
        send({6'h0D, 5'd0, 5'd4, 16'hFFFF}, 32'h0000_0080);
        n_cmp++; if (out_b !== 32'h0000_FFFF) begin n_bad++; $display("FAIL ori_imm: got %h want 0000ffff", out_b); end
        n_cmp++; if (out_op !== 4'd3) begin n_bad++; $display("FAIL ori_op: got %0d want 3", out_op); end
        send({6'h08, 5'd0, 5'd4, 16'hFFFF}, 32'h0000_0084);
        n_cmp++; if (out_b !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL addi_imm: got %h want ffffffff", out_b); end
        n_cmp++; if (out_op !== 4'd0) begin n_bad++; $display("FAIL addi_op: got %0d want 0", out_op); end
    endtask

    task automatic test_branch();
        send({6'h04, 5'd1, 5'd1, 16'd3}, 32'h0000_0100);
        n_cmp++; if (redirect !== 1'b1) begin n_bad++; $display("FAIL beq_taken: got %b want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h0000_0110) begin n_bad++; $display("FAIL beq_target: got %h want 00000110", redirect_pc); end
        n_cmp++; if (out_wreg !== 1'b0) begin n_bad++; $display("FAIL beq_wreg: got %b want 0", out_wreg); end
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL beq_pulse: got %b want 0", redirect); end
        send({6'h04, 5'd1, 5'd2, 16'd3}, 32'h0000_0100);
        n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL beq_not_taken: got %b want 0", redirect); end
    endtask

    task automatic test_load_use();
        regs[5] = 32'hDEAD_0000;
        send({6'h23, 5'd1, 5'd5, 16'd0}, 32'h0000_0200);
        n_cmp++; if (out_mem_rd !== 1'b1 || out_waddr !== 5'd5) begin n_bad++; $display("FAIL lw_decode: got rd=%b waddr=%0d want 1/5", out_mem_rd, out_waddr); end
        in_valid = 1'b1; in_ins = {6'h00, 5'd5, 5'd5, 5'd6, 5'd0, 6'h20}; in_pc = 32'h0000_0204;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL load_use_stall[%0d]: got %b want 0", i, in_ready); end
            @(negedge clk);
        end
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234; #1;
`ifdef WB_BYPASS_EN
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL wb_cycle_ready: got %b want 1", in_ready); end
        @(posedge clk); @(negedge clk);
        wb_en = 1'b0; in_valid = 1'b0; regs[5] = 32'h0000_1234; #1;
`else
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL wb_cycle_ready: got %b want 0", in_ready); end
        @(posedge clk); @(negedge clk);
        wb_en = 1'b0; regs[5] = 32'h0000_1234; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL after_wb_ready: got %b want 1", in_ready); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
`endif
        n_cmp++; if (out_valid !== 1'b1 || out_waddr !== 5'd6) begin n_bad++; $display("FAIL dep_issue: got v=%b waddr=%0d want 1/6", out_valid, out_waddr); end
        n_cmp++; if (out_a !== 32'h0000_1234 || out_b !== 32'h0000_1234) begin n_bad++; $display("FAIL dep_operands: got %h %h want 00001234", out_a, out_b); end
        @(negedge clk);
    endtask

    task automatic test_backpressure_flush();
        regs[2] = 32'h0000_0700;
        send({6'h23, 5'd2, 5'd7, 16'd4}, 32'h0000_0300);
        out_ready = 1'b0;
        in_valid = 1'b1; in_ins = {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20}; in_pc = 32'h0000_0304;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_waddr !== 5'd7 || out_mem_rd !== 1'b1) begin n_bad++; $display("FAIL hold_ctrl[%0d]: got v=%b waddr=%0d rd=%b want 1/7/1", i, out_valid, out_waddr, out_mem_rd); end
            n_cmp++; if (out_a !== 32'h0000_0700 || out_b !== 32'd4) begin n_bad++; $display("FAIL hold_ab[%0d]: got %h %h want 00000700 00000004", i, out_a, out_b); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
            @(negedge clk);
        end
        flush = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        out_ready = 1'b1; in_valid = 1'b1; in_ins = {6'h00, 5'd7, 5'd7, 5'd9, 5'd0, 6'h20}; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_busy_clear: got %b want 1", in_ready); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_waddr !== 5'd9) begin n_bad++; $display("FAIL post_flush_issue: got v=%b waddr=%0d want 1/9", out_valid, out_waddr); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        send({6'h23, 5'd1, 5'd10, 16'd0}, 32'h0000_0400);
        out_ready = 1'b0;
        in_valid = 1'b1; in_ins = {6'h00, 5'd10, 5'd1, 5'd11, 5'd0, 6'h20}; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_stall_ready: got %b want 0", in_ready); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0 || out_mem_rd !== 1'b0 || out_waddr !== 5'd0) begin n_bad++; $display("FAIL mid_reset_clear: got v=%b rd=%b waddr=%0d want 0/0/0", out_valid, out_mem_rd, out_waddr); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 1", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_waddr !== 5'd11) begin n_bad++; $display("FAIL mid_reset_issue: got v=%b waddr=%0d want 1/11", out_valid, out_waddr); end
        @(negedge clk);
    endtask

    task automatic test_jal_illegal();
        send({6'h03, 26'h10}, 32'h0040_0000);
        n_cmp++; if (redirect !== 1'b1 || redirect_pc !== 32'h0000_0040) begin n_bad++; $display("FAIL jal_redirect: got %b %h want 1 00000040", redirect, redirect_pc); end
        n_cmp++; if (out_a !== 32'h0040_0008) begin n_bad++; $display("FAIL jal_link: got %h want 00400008", out_a); end
        n_cmp++; if (out_waddr !== 5'd31 || out_wreg !== 1'b1) begin n_bad++; $display("FAIL jal_dst: got %0d/%b want 31/1", out_waddr, out_wreg); end
        send({6'h3F, 26'h2A5_5A5A}, 32'h0000_0500);
        n_cmp++; if (out_illegal !== 1'b1 || out_wreg !== 1'b0) begin n_bad++; $display("FAIL illegal_flags: got ill=%b wreg=%b want 1/0", out_illegal, out_wreg); end
        n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL illegal_redirect: got %b want 0", redirect); end
    endtask

    task automatic test_random();
        logic [31:0] ins, pc;
        logic [5:0]  opc;
        exp_t        e;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int r = 1; r < 32; r++) regs[r] = $urandom;
        regs[3] = 32'd0; regs[4] = 32'h8000_0000;
        for (int i = 0; i < 300; i++) begin
            opc = OPC_TAB[$urandom_range(0, 22)];
            ins = $urandom;
            ins[31:26] = opc;
            if (opc == 6'h00) ins[5:0] = FN_TAB[$urandom_range(0, 19)];
            if (opc == 6'h23) ins[20:16] = 5'd0;
            if ((opc == 6'h04 || opc == 6'h05) && $urandom_range(0, 1) == 1) ins[20:16] = ins[25:21];
            pc = $urandom & 32'hFFFF_FFFC;
            e = model(ins, pc, regs[ins[25:21]], regs[ins[20:16]]);
            in_valid = 1'b1; in_ins = ins; in_pc = pc; #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want 1 ins=%h", i, in_ready, ins); end
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if ({out_illegal, out_wreg, out_mem_rd, out_mem_wr} !== {e.ill, e.wreg, e.mrd, e.mwr}) begin n_bad++; $display("FAIL rnd_flags[%0d]: got %b want %b ins=%h", i, {out_illegal, out_wreg, out_mem_rd, out_mem_wr}, {e.ill, e.wreg, e.mrd, e.mwr}, ins); end
            n_cmp++; if (redirect !== e.redir) begin n_bad++; $display("FAIL rnd_redirect[%0d]: got %b want %b ins=%h", i, redirect, e.redir, ins); end
            if (e.redir) begin
                n_cmp++; if (redirect_pc !== e.rpc) begin n_bad++; $display("FAIL rnd_target[%0d]: got %h want %h ins=%h", i, redirect_pc, e.rpc, ins); end
            end
            if (e.wreg) begin
                n_cmp++; if (out_waddr !== e.waddr) begin n_bad++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d ins=%h", i, out_waddr, e.waddr, ins); end
            end
            if (e.chk_op) begin
                n_cmp++; if (out_op !== e.op) begin n_bad++; $display("FAIL rnd_op[%0d]: got %0d want %0d ins=%h", i, out_op, e.op, ins); end
            end
            if (e.chk_ab) begin
                n_cmp++; if (out_a !== e.a || out_b !== e.b) begin n_bad++; $display("FAIL rnd_ab[%0d]: got %h %h want %h %h ins=%h", i, out_a, out_b, e.a, e.b, ins); end
            end
            if (e.mwr) begin
                n_cmp++; if (out_store !== e.store) begin n_bad++; $display("FAIL rnd_store[%0d]: got %h want %h", i, out_store, e.store); end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h1000 + r;
        regs[0] = 32'd0;
        in_valid = 0; in_ins = 0; in_pc = 0; out_ready = 1; flush = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; rst = 1;
        @(negedge clk);
        test_reset();
        test_alu();
        test_imm();
        test_branch();
        test_load_use();
        test_backpressure_flush();
        test_reset_mid_stall();
        test_jal_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_decode_stage.md
Name: mips_decode_stage

Overview:
- Registered MIPS-I decode/issue stage sitting between fetch and a separate ALU/memory execute stage.
- Decodes one instruction per cycle and reads operands from the register file.
- Resolves branches and jumps, then issues a fully-decoded micro-op through a valid/ready pipeline register.
- A per-register scoreboard stalls instructions whose sources are pending writes (long-latency loads / multi-cycle results) until writeback.

Parameters:
- DATA_W, 32, datapath and PC width.
- NREG, 32, architectural registers; register address width RA_W = clog2(NREG).
- OP_W, 4, ALU operation code width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_ins  in  32  instruction word
- in_pc  in  DATA_W  PC of in_ins
- rf_raddr1 / rf_raddr2  out  RA_W  register file read addresses (rs / rt), combinational from in_ins
- rf_rdata1 / rf_rdata2  in  DATA_W  register file read data, same cycle
- wb_en  in  1  writeback occurring
- wb_addr  in  RA_W  writeback register
- wb_data  in  DATA_W  writeback value
- flush  in  1  kill held micro-op, clear scoreboard
- out_valid  out  1  micro-op valid
- out_ready  in  1  execute accepts micro-op
- out_op  out  OP_W  ALU op: ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOR=5 SLT=6 SLTU=7 SLL=8 SRL=9 SRA=10 LUI=11
- out_a / out_b  out  DATA_W  ALU operands
- out_store  out  DATA_W  store data (rt)
- out_waddr  out  RA_W  destination register
- out_wreg  out  1  destination written
- out_mem_rd / out_mem_wr  out  1  load / store
- out_illegal  out  1  unsupported encoding
- redirect  out  1  one-cycle control-flow redirect pulse
- redirect_pc  out  DATA_W  redirect target

Behaviour:
- Reset: every out_* register, redirect and redirect_pc cleared to 0; all scoreboard bits cleared.
- Accept condition: in_valid & in_ready. Issue condition: out_valid & out_ready.
- in_ready = !stall & (!out_valid | out_ready) & !flush.
- Accepted instruction appears on out_* the next cycle; latency 1.
- Registered outputs hold stable while out_valid & !out_ready.
- Decode: rd destination for R-type, rt for I-type, 31 for JAL.
- Immediates: sign-extended for ADDI/ADDIU/SLTI/LW/SW; zero-extended for ANDI/ORI/XORI; SLTIU compares as unsigned against the sign-extended immediate.
- Shifts: out_a = shamt (or rs[4:0] for the V-forms), out_b = rt. SUB/SUBU map to SUB.
- Loads/stores use op ADD with out_a = rs, out_b = imm.
- Writes to register 0 force out_wreg = 0.
- Branches: BEQ/BNE/BLEZ/BGTZ compare in this stage. When taken, redirect = 1 and redirect_pc = pc + 4 + (sext(imm) << 2).
- Jumps: J/JAL target = {pc+4[31:28], idx, 00}; JR target = rs.
- JAL issues op ADD with out_a = pc + 8, out_b = 0. Branches, J and JR issue with out_wreg = 0.
- redirect is registered: high exactly one cycle, in the cycle after acceptance. There is no delay slot; fetch discards its wrong-path instruction.
- Unknown opcode/funct: out_illegal = 1, out_wreg = 0, no redirect.
- Scoreboard: busy[r] is set on accept of any instruction with out_wreg & out_mem_rd, and cleared on wb_en & wb_addr == r.
- Same-register set and clear in one cycle: set wins. busy[0] is always 0.
- stall = (rs used & busy[rs]) | (rt used & busy[rt]). rt counts as used for R-type ALU ops, BEQ/BNE and SW.
- flush: out_valid <= 0, redirect <= 0, all busy bits cleared, no accept that cycle. Flush takes priority over out_ready and over wb_en.
- rst asserted mid-stall or mid-backpressure drops the held micro-op; no partial state survives.

Optional Feature:
- WB_BYPASS_EN defined:
  - When wb_en matches a source register (nonzero), wb_data replaces rf_rdata for that operand.
  - The matching busy bit does not stall in that cycle; a dependent instruction issues in the writeback cycle.
- WB_BYPASS_EN undefined:
  - Operands come only from rf_rdata.
  - A dependent instruction is accepted one cycle after writeback clears the busy bit.

Test Plan:
- After reset, out_valid = 0 and redirect = 0. ADDU $3,$1,$2 with rdata 5, 7 -> next cycle out_op = 0, out_a = 5, out_b = 7, out_waddr = 3, out_wreg = 1.
- ORI $4,$0,0xFFFF -> out_b = 0x0000FFFF, op OR. ADDI $4,$0,-1 -> out_b = 0xFFFFFFFF.
- BEQ at pc 0x100, imm 3, equal operands -> redirect = 1 for exactly one cycle with redirect_pc = 0x110. Unequal operands -> redirect stays 0.
- LW $5 accepted, then ADD $6,$5,$5 -> in_ready = 0 until wb_en & wb_addr = 5.
  - Without WB_BYPASS_EN: accepted the cycle after writeback.
  - With WB_BYPASS_EN: accepted in the writeback cycle with out_a = wb_data.
- out_ready held 0 for 3 cycles -> out_* unchanged and in_ready = 0. Then flush -> out_valid = 0 and busy cleared.
- JAL at pc 0x0040_0000, idx 0x10 -> redirect_pc = 0x0000_0040, out_a = 0x0040_0008, out_waddr = 31. Illegal opcode 0x3F -> out_illegal = 1, out_wreg = 0.
